// File: rtl/dadda_seq_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier built on a
// 4x4 Dadda core.
//   state_e     : controller states
//   operands_t  : latched operand pair
//   align_pp    : zero-extends a 4x4 partial product and places it at the
//                 bit offset belonging to a given step
package dadda_seq_pkg;

  localparam int unsigned NUM_STEPS = 4;
  localparam int unsigned HALF_W    = 4;
  localparam int unsigned OP_W      = 8;
  localparam int unsigned PROD_W    = 16;
  localparam int unsigned PP_W      = 2 * HALF_W;
  localparam int unsigned STEP_W    = 2;

  // Offsets for AL*BL, AH*BL, AL*BH, AH*BH in step order.
  localparam int unsigned STEP_SHIFT [NUM_STEPS] = '{0, 4, 4, 8};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } operands_t;

  // Place one partial product into the 16-bit accumulator frame.
  function automatic logic [PROD_W-1:0] align_pp(input logic [PP_W-1:0]   pp,
                                                 input logic [STEP_W-1:0] step);
    return PROD_W'(pp) << STEP_SHIFT[step];
  endfunction

endpackage

// File: rtl/dadda_unsigned_multiplier_4.sv
// Combinational 4x4 unsigned multiplier using a Dadda reduction tree.
//   a_i       : 4-bit multiplicand
//   b_i       : 4-bit multiplier
//   product_o : 8-bit product, combinational
// Column heights 1,2,3,4,3,2,1 are reduced to at most 3, then to 2, and the
// two remaining rows go through a final carry-propagate add.
module dadda_unsigned_multiplier_4
  import dadda_seq_pkg::*;
(
  input  logic [HALF_W-1:0] a_i,
  input  logic [HALF_W-1:0] b_i,
  output logic [PP_W-1:0]   product_o
);

  // Returns {carry, sum}.
  function automatic logic [1:0] ha(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  // Returns {carry, sum}.
  function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

  // pp[i][j] = b[i] & a[j], weight i+j.
  logic [HALF_W-1:0][HALF_W-1:0] pp;

  always_comb begin
    for (int i = 0; i < int'(HALF_W); i++) begin
      for (int j = 0; j < int'(HALF_W); j++) begin
        pp[i][j] = b_i[i] & a_i[j];
      end
    end
  end

  // Stage 1: max height 4 -> 3.
  logic [1:0] s1_c3;
  logic [1:0] s1_c4;
  assign s1_c3 = ha(pp[0][3], pp[1][2]);
  assign s1_c4 = ha(pp[1][3], pp[2][2]);

  // Stage 2: max height 3 -> 2.
  logic [1:0] s2_c2;
  logic [1:0] s2_c3;
  logic [1:0] s2_c4;
  logic [1:0] s2_c5;
  assign s2_c2 = ha(pp[0][2], pp[1][1]);
  assign s2_c3 = fa(s1_c3[0], pp[2][1], pp[3][0]);
  assign s2_c4 = fa(s1_c4[0], pp[3][1], s1_c3[1]);
  assign s2_c5 = fa(pp[2][3], pp[3][2], s1_c4[1]);

  // Two remaining rows; bit 7 of each is empty.
  logic [PP_W-1:0] row0;
  logic [PP_W-1:0] row1;
  assign row0 = {1'b0, pp[3][3], s2_c5[0], s2_c4[0], s2_c3[0], s2_c2[0],
                 pp[0][1], pp[0][0]};
  assign row1 = {1'b0, s2_c5[1], s2_c4[1], s2_c3[1], s2_c2[1], pp[2][0],
                 pp[1][0], 1'b0};

  assign product_o = row0 + row1;

endmodule

// File: rtl/dadda_seq_multiplier_8.sv
// Sequential 8x8 unsigned multiplier. One operand pair is accepted on a
// valid/ready handshake, the four 4x4 partial products are computed over four
// cycles on a single shared Dadda core and accumulated, and the 16-bit result
// is offered on a valid/ready output.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready is combinational)
//   a, b                 : 8-bit unsigned operands
//   out_valid / out_ready: result handshake
//   product              : registered 16-bit result
//   busy                 : high while the partial products are being summed
module dadda_seq_multiplier_8
  import dadda_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product,
  output logic              busy
);

  state_e              state_q;
  logic [STEP_W-1:0]   step_q;
  operands_t           ops_q;
  logic [PROD_W-1:0]   acc_q;
  logic [PROD_W-1:0]   acc_d;
  logic [PROD_W-1:0]   product_q;
  logic                out_valid_q;
  logic                busy_q;

  logic [HALF_W-1:0]   core_a;
  logic [HALF_W-1:0]   core_b;
  logic [PP_W-1:0]     core_pp;

  // A finished result may be handed off and a new pair taken on the same edge.
  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);

  // Step bit 0 picks the A half, bit 1 the B half: AL*BL, AH*BL, AL*BH, AH*BH.
  always_comb begin
    core_a = step_q[0] ? ops_q.a[OP_W-1:HALF_W] : ops_q.a[HALF_W-1:0];
    core_b = step_q[1] ? ops_q.b[OP_W-1:HALF_W] : ops_q.b[HALF_W-1:0];
    acc_d  = acc_q + align_pp(core_pp, step_q);
  end

  dadda_unsigned_multiplier_4 u_core (
    .a_i       (core_a),
    .b_i       (core_b),
    .product_o (core_pp)
  );

  // Controller, operand capture and accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= '0;
      ops_q       <= '0;
      acc_q       <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            ops_q   <= '{a: a, b: b};
            acc_q   <= '0;
            step_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end

        CALC: begin
          acc_q <= acc_d;
          if (step_q == STEP_W'(NUM_STEPS - 1)) begin
            product_q   <= acc_d;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            step_q      <= '0;
            state_q     <= DONE;
          end else begin
            step_q <= step_q + STEP_W'(1);
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              ops_q   <= '{a: a, b: b};
              acc_q   <= '0;
              step_q  <= '0;
              busy_q  <= 1'b1;
              state_q <= CALC;
            end else begin
              state_q <= IDLE;
            end
          end
        end

        default: begin
          state_q     <= IDLE;
          step_q      <= '0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dadda_seq_multiplier_8.sv
// Bench for dadda_seq_multiplier_8: expected products are queued when an
// operand pair is accepted; a monitor pops and compares on every output
// transfer. Inputs change 1 time unit after the rising edge, everything is
// sampled on the falling edge.
module tb_dadda_seq_multiplier_8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  int          errors  = 0;
  int          checks  = 0;
  int          accepts = 0;
  int          results = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;
  logic        rand_or = 1'b0;

  always #5 clk = ~clk;

  dadda_seq_multiplier_8 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Offer a pair until accepted, queue its expected product, then scramble
  // the input bus so a late re-sample would corrupt the result.
  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [15:0] e);
    int n;
    n = 0;
    in_valid = 1'b1;
    a = x;
    b = y;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: in_ready=0 expected 1 after %0d cycles", n);
    end else begin
      exp_q.push_back(e);
      accepts++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~x;
    b = ~y;
  endtask

  // Wait until every accepted pair has produced a result.
  task automatic wait_done();
    int n;
    n = 0;
    while (results != accepts && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_count", 32'(results), 32'(accepts));
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected: got 0x%0h with nothing pending", product);
      end else begin
        mon_exp = exp_q.pop_front();
        if (product !== mon_exp) begin
          errors++;
          $display("FAIL result_value: got 0x%0h expected 0x%0h at %0t",
                   product, mon_exp, $time);
        end
      end
      results++;
    end
  end

  // Random backpressure source.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_or) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int cnt;
    logic [7:0] rx;
    logic [7:0] ry;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_product", 32'(product), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;

    // Full-scale operands; busy must last exactly four cycles.
    out_ready = 1'b1;
    send(8'hFF, 8'hFF, 16'hFE01);
    n = 0;
    cnt = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      if (busy) cnt++;
      n++;
    end
    chk("ff_busy_cycles", 32'(cnt), 4);
    chk("ff_out_valid", 32'(out_valid), 1);
    chk("ff_product", 32'(product), 32'h0000FE01);
    chk("ff_busy_done", 32'(busy), 0);
    @(negedge clk);
    chk("ff_idle_out_valid", 32'(out_valid), 0);
    chk("ff_idle_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;

    // Zero operand and a mixed pair; inputs scrambled after acceptance.
    send(8'h00, 8'hA5, 16'h0000);
    wait_done();
    send(8'h12, 8'h34, 16'h03A8);
    wait_done();

    // Backpressure: 0x21*0x43 = 33*67 = 2211.
    out_ready = 1'b0;
    send(8'h21, 8'h43, 16'h08A3);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a = 8'h11;
    b = 8'h11;
    repeat (10) begin
      @(negedge clk);
      chk("bp_product", 32'(product), 32'h000008A3);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_in_ready", 32'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'h11, 8'h11, 16'h0121);
    @(negedge clk);
    chk("b2b_busy", 32'(busy), 1);
    chk("b2b_out_valid", 32'(out_valid), 0);
    wait_done();

    // Streaming; 0xC3*0x5A = 195*90 = 17550.
    send(8'h0F, 8'h10, 16'h00F0);
    send(8'h80, 8'h02, 16'h0100);
    send(8'hC3, 8'h5A, 16'h448E);
    wait_done();

    // Reset during step 2 discards the pending result.
    send(8'h55, 8'h66, 16'h21DE);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    exp_q.delete();
    accepts = results;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_product", 32'(product), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    send(8'h07, 8'h09, 16'h003F);
    wait_done();

    // Random pairs with random gaps and random backpressure.
    rand_or = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      rx = 8'($urandom);
      ry = 8'($urandom);
      send(rx, ry, 16'(rx) * 16'(ry));
    end
    rand_or = 1'b0;
    out_ready = 1'b1;
    wait_done();
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
